// File: rtl/gpu_pkg.sv
// Shared GPU-side definitions: arbiter state encoding, default memory geometry
// and the round-robin pointer helper used by the shared-memory arbiter.
package gpu_pkg;

   localparam int ADDR_W_DEF    = 12;
   localparam int DATA_W_DEF    = 8;
   localparam int NUM_CORES_MAX = 16;
   localparam int GRANT_W       = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arbState_t;

   // Pointer to the core after the winner, wrapping at the configured core count.
   function automatic logic [GRANT_W-1:0] nextPtr(input logic [GRANT_W-1:0] winner,
                                                  input int numCores);
      if (int'(winner) == numCores - 1) begin
         return '0;
      end
      return winner + 1'b1;
   endfunction

endpackage

// File: rtl/sm_ram.sv
// Single-port shared memory with synchronous read and write; a write returns
// the written byte on the read port so stores can be echoed back to the core.
module sm_ram
   import gpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
         end else begin
            o_rdata <= r_mem[i_addr];
         end
      end
   end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising per-core load/store requests onto one
// shared memory; each access takes IDLE -> ACCESS -> RESP.
module shared_mem_arbiter
   import gpu_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        mem_req_ld,
   input  logic [NUM_CORES-1:0]        mem_req_st,
   input  logic [NUM_CORES*ADDR_W-1:0] addr_shared_memory,
   input  logic [NUM_CORES*DATA_W-1:0] mem_dat_st,
   output logic [DATA_W-1:0]           mem_dat,
   output logic [NUM_CORES-1:0]        val_data,
   output logic                        busy,
   output logic [GRANT_W-1:0]          grant_id
);

   arbState_t          r_state;
   arbState_t          w_nextState;
   logic [GRANT_W-1:0] r_rrPtr;
   logic [GRANT_W-1:0] r_grantId;
   logic               r_isLoad;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_memDatHold;

   logic [NUM_CORES-1:0] w_req;
   logic                 w_found;
   logic [GRANT_W-1:0]   w_winner;
   int                   w_bestDist;
   logic [ADDR_W-1:0]    w_winAddr;
   logic [DATA_W-1:0]    w_winData;
   logic                 w_winIsLoad;
   logic                 w_ramEn;
   logic                 w_ramWe;
   logic [DATA_W-1:0]    w_ramRdata;

   assign w_req = mem_req_ld | mem_req_st;

   // The winner is the requester closest to rr_ptr going upward with wrap.
   always_comb begin
      w_found    = 1'b0;
      w_winner   = '0;
      w_bestDist = NUM_CORES;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (w_req[k] && (((k + NUM_CORES - int'(r_rrPtr)) % NUM_CORES) < w_bestDist)) begin
            w_bestDist = (k + NUM_CORES - int'(r_rrPtr)) % NUM_CORES;
            w_winner   = GRANT_W'(k);
            w_found    = 1'b1;
         end
      end
   end

   // A load beats a simultaneous store from the same core.
   always_comb begin
      w_winAddr   = '0;
      w_winData   = '0;
      w_winIsLoad = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (w_winner == GRANT_W'(k)) begin
            w_winAddr   = addr_shared_memory[k*ADDR_W +: ADDR_W];
            w_winData   = mem_dat_st[k*DATA_W +: DATA_W];
            w_winIsLoad = mem_req_ld[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_found) w_nextState = ACCESS;
         ACCESS:  w_nextState = RESP;
         RESP:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rrPtr      <= '0;
         r_grantId    <= '0;
         r_isLoad     <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_memDatHold <= '0;
      end else begin
         if (r_state == IDLE && w_found) begin
            r_grantId <= w_winner;
            r_isLoad  <= w_winIsLoad;
            r_addr    <= w_winAddr;
            r_wdata   <= w_winData;
            r_rrPtr   <= nextPtr(w_winner, NUM_CORES);
         end
         if (r_state == RESP) begin
            r_memDatHold <= w_ramRdata;
         end
      end
   end

   assign w_ramEn = (r_state == ACCESS);
   assign w_ramWe = (r_state == ACCESS) && !r_isLoad;

   sm_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .i_en    (w_ramEn),
      .i_we    (w_ramWe),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ramRdata)
   );

   // Response strobe exists only in RESP, so reset kills it immediately.
   always_comb begin
      val_data = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         val_data[k] = (r_state == RESP) && (r_grantId == GRANT_W'(k));
      end
   end

   assign mem_dat  = (r_state == RESP) ? w_ramRdata : r_memDatHold;
   assign busy     = (r_state != IDLE);
   assign grant_id = r_grantId;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: table-driven single accesses plus
// hand-written arbitration, latency and reset sequences, checked by a scoreboard.
module tb_shared_mem_arbiter;

   localparam int NC = 4;
   localparam int AW = 12;
   localparam int DW = 8;

   logic              clk;
   logic              reset;
   logic [NC-1:0]     mem_req_ld;
   logic [NC-1:0]     mem_req_st;
   logic [NC*AW-1:0]  addr_shared_memory;
   logic [NC*DW-1:0]  mem_dat_st;
   logic [DW-1:0]     mem_dat;
   logic [NC-1:0]     val_data;
   logic              busy;
   logic [3:0]        grant_id;

   int checks = 0;
   int errors = 0;
   int cycleCnt = 0;

   typedef struct {
      int          core;
      logic [7:0]  data;
   } expEntry_t;

   typedef struct {
      int          core;
      bit          ld;
      bit          st;
      logic [11:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  expData;
   } vec_t;

   expEntry_t expQ[$];
   expEntry_t monEntry;
   vec_t      vecs[13];

   shared_mem_arbiter #(
      .NUM_CORES (NC),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .mem_req_ld         (mem_req_ld),
      .mem_req_st         (mem_req_st),
      .addr_shared_memory (addr_shared_memory),
      .mem_dat_st         (mem_dat_st),
      .mem_dat            (mem_dat),
      .val_data           (val_data),
      .busy               (busy),
      .grant_id           (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Scoreboard: every strobe must be one-hot and match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && val_data !== '0) begin
         checkOutput("val_data onehot", 32'($countones(val_data)), 32'd1);
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected strobe: got val_data 0x%0h, expected none", val_data);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("strobe core", 32'(val_data), 32'(1 << monEntry.core));
            checkOutput("mem_dat", 32'(mem_dat), 32'(monEntry.data));
         end
      end
   end

   // Raise one core's request, hold it until its strobe, drop it on the next edge.
   task automatic applyStimulus(input int core, input bit ld, input bit st,
                                input logic [11:0] addr, input logic [7:0] wdata,
                                output int strobeCyc);
      bit got;
      got = 1'b0;
      strobeCyc = -1;
      addr_shared_memory[core*AW +: AW] = addr;
      mem_dat_st[core*DW +: DW] = wdata;
      mem_req_ld[core] = ld;
      mem_req_st[core] = st;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (val_data[core] === 1'b1) begin
            got = 1'b1;
            strobeCyc = cycleCnt;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL response timeout core %0d: got no strobe, expected one within 60 cycles", core);
      end
      @(posedge clk);
      #1;
      mem_req_ld[core] = 1'b0;
      mem_req_st[core] = 1'b0;
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic expEntry_t mk(input int core, input logic [7:0] data);
      expEntry_t e;
      e.core = core;
      e.data = data;
      return e;
   endfunction

   initial begin
      int sc;
      int s[4];
      int c1s[3];
      bit seen;

      reset = 1'b1;
      mem_req_ld = '0;
      mem_req_st = '0;
      addr_shared_memory = '0;
      mem_dat_st = '0;

      vecs[0]  = '{1, 1'b0, 1'b1, 12'h123, 8'hA5, 8'hA5};
      vecs[1]  = '{2, 1'b1, 1'b0, 12'h123, 8'h00, 8'hA5};
      vecs[2]  = '{0, 1'b0, 1'b1, 12'h010, 8'h11, 8'h11};
      vecs[3]  = '{0, 1'b1, 1'b1, 12'h010, 8'h77, 8'h11};
      vecs[4]  = '{3, 1'b1, 1'b0, 12'h010, 8'h00, 8'h11};
      vecs[5]  = '{2, 1'b0, 1'b1, 12'hFFF, 8'h3C, 8'h3C};
      vecs[6]  = '{1, 1'b1, 1'b0, 12'hFFF, 8'h00, 8'h3C};
      vecs[7]  = '{3, 1'b0, 1'b1, 12'h000, 8'hC3, 8'hC3};
      vecs[8]  = '{0, 1'b1, 1'b0, 12'h000, 8'h00, 8'hC3};
      vecs[9]  = '{1, 1'b1, 1'b0, 12'h123, 8'h00, 8'hA5};
      vecs[10] = '{2, 1'b0, 1'b1, 12'h800, 8'h5A, 8'h5A};
      vecs[11] = '{3, 1'b1, 1'b0, 12'h800, 8'h00, 8'h5A};
      vecs[12] = '{0, 1'b1, 1'b0, 12'hFFF, 8'h00, 8'h3C};

      #2;
      checkOutput("reset val_data", 32'(val_data), 32'd0);
      checkOutput("reset mem_dat", 32'(mem_dat), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset grant_id", 32'(grant_id), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int v = 0; v < 13; v++) begin
         expQ.push_back(mk(vecs[v].core, vecs[v].expData));
         applyStimulus(vecs[v].core, vecs[v].ld, vecs[v].st, vecs[v].addr, vecs[v].wdata, sc);
         checkOutput("grant_id after access", 32'(grant_id), 32'(vecs[v].core));
      end

      // Latency of a lone core3 load raised just after edge t.
      expQ.push_back(mk(3, 8'hA5));
      addr_shared_memory[3*AW +: AW] = 12'h123;
      mem_req_ld[3] = 1'b1;
      @(negedge clk);
      checkOutput("lat busy t", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("lat busy t+1", 32'(busy), 32'd1);
      checkOutput("lat val t+1", 32'(val_data), 32'd0);
      @(negedge clk);
      checkOutput("lat busy t+2", 32'(busy), 32'd1);
      checkOutput("lat val t+2", 32'(val_data), 32'b1000);
      @(posedge clk);
      #1 mem_req_ld[3] = 1'b0;
      @(negedge clk);
      checkOutput("lat busy t+3", 32'(busy), 32'd0);
      checkOutput("lat val t+3", 32'(val_data), 32'd0);
      checkOutput("mem_dat held", 32'(mem_dat), 32'hA5);

      // All four cores load at once from rr_ptr=0.
      pulseReset();
      expQ.push_back(mk(0, 8'hA5));
      expQ.push_back(mk(1, 8'h3C));
      expQ.push_back(mk(2, 8'hC3));
      expQ.push_back(mk(3, 8'h5A));
      fork
         applyStimulus(0, 1'b1, 1'b0, 12'h123, 8'h00, s[0]);
         applyStimulus(1, 1'b1, 1'b0, 12'hFFF, 8'h00, s[1]);
         applyStimulus(2, 1'b1, 1'b0, 12'h000, 8'h00, s[2]);
         applyStimulus(3, 1'b1, 1'b0, 12'h800, 8'h00, s[3]);
      join
      checkOutput("rr spacing 0-1", 32'(s[1] - s[0]), 32'd3);
      checkOutput("rr spacing 1-2", 32'(s[2] - s[1]), 32'd3);
      checkOutput("rr spacing 2-3", 32'(s[3] - s[2]), 32'd3);

      // rr_ptr back at 0: core0 must beat core3.
      expQ.push_back(mk(0, 8'h11));
      expQ.push_back(mk(3, 8'hA5));
      fork
         applyStimulus(0, 1'b1, 1'b0, 12'h010, 8'h00, s[0]);
         applyStimulus(3, 1'b1, 1'b0, 12'h123, 8'h00, s[3]);
      join
      checkOutput("rr wrap core0 first", 32'(s[0] < s[3]), 32'd1);

      // Reset while a core2 load is in ACCESS.
      addr_shared_memory[2*AW +: AW] = 12'h000;
      mem_req_ld[2] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (busy === 1'b1) seen = 1'b1;
      end
      checkOutput("abort reached ACCESS", 32'(seen), 32'd1);
      #1 reset = 1'b1;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort val_data", 32'(val_data), 32'd0);
      checkOutput("abort grant_id", 32'(grant_id), 32'd0);
      checkOutput("abort mem_dat", 32'(mem_dat), 32'd0);
      @(posedge clk);
      #1 mem_req_ld[2] = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      expQ.push_back(mk(1, 8'hC3));
      expQ.push_back(mk(3, 8'h5A));
      fork
         applyStimulus(1, 1'b1, 1'b0, 12'h000, 8'h00, s[1]);
         applyStimulus(3, 1'b1, 1'b0, 12'h800, 8'h00, s[3]);
      join
      checkOutput("post-abort core1 first", 32'(s[1] < s[3]), 32'd1);

      // Core1 hammers the arbiter; core0 asks once and must not starve.
      expQ.push_back(mk(1, 8'h3C));
      expQ.push_back(mk(0, 8'h11));
      expQ.push_back(mk(1, 8'h3C));
      expQ.push_back(mk(1, 8'h3C));
      fork
         begin
            for (int r = 0; r < 3; r++) begin
               applyStimulus(1, 1'b1, 1'b0, 12'hFFF, 8'h00, c1s[r]);
               @(posedge clk);
               #1;
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            applyStimulus(0, 1'b1, 1'b0, 12'h010, 8'h00, s[0]);
         end
      join
      checkOutput("no starvation", 32'((s[0] > c1s[0]) && (s[0] < c1s[1])), 32'd1);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
